// File: rtl/fetch_queue_if.sv
// Fetch queue bus bundle: instruction-memory request/response channel,
// branch redirect input and the decode-side valid/ready output channel.
// The master modport is the fetch queue itself; the slave modport is the
// surrounding environment (memory, branch logic and decode).
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          imem_req;
  logic [63:0]   imem_addr;
  logic          imem_ready;
  logic          imem_rvalid;
  logic [31:0]   imem_rdata;
  logic          redirect;
  logic [63:0]   redirect_pc;
  logic [31:0]   instr_out;
  logic [63:0]   pcaddr_out;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;

  modport master (
    output imem_req, imem_addr, instr_out, pcaddr_out, out_valid, count,
    input  imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_out, pcaddr_out, out_valid, count,
    output imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue. Issues sequential fetch requests while the sum
// of stored entries and in-flight requests is below DEPTH, so every kept
// response is guaranteed a free slot. A redirect flushes the buffer, reloads
// both PCs and marks every still-outstanding response to be discarded.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);
  localparam int          CW      = $clog2(DEPTH + 1);
  localparam int          PW      = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [63:0]   fetch_pc;
  logic [63:0]   resp_pc;
  logic [31:0]   instr_mem [DEPTH];
  logic [63:0]   pc_mem    [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count_q;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;

  logic [CW:0]   in_use;
  logic          issue;
  logic          accept;
  logic          resp;
  logic          keep;
  logic          deq;
  logic [CW-1:0] outstanding_next;

  // Request gating plus classification of this cycle's response and dequeue;
  // a response with nothing outstanding is ignored so the counters never wrap
  always_comb begin
    in_use           = {1'b0, count_q} + {1'b0, outstanding};
    issue            = !rst && !bus.redirect && (in_use < DEPTH_W);
    accept           = issue && bus.imem_ready;
    resp             = bus.imem_rvalid && (outstanding != '0);
    keep             = resp && (drop == '0);
    deq              = (count_q != '0) && bus.out_ready;
    outstanding_next = outstanding + CW'(accept) - CW'(resp);
  end

  // Pointers, occupancy, in-flight/drop bookkeeping and the two PCs;
  // redirect outranks everything except reset and ignores any dequeue
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count_q     <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else if (bus.redirect) begin
      fetch_pc    <= bus.redirect_pc;
      resp_pc     <= bus.redirect_pc;
      head        <= '0;
      tail        <= '0;
      count_q     <= '0;
      outstanding <= outstanding_next;
      drop        <= outstanding_next;
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + 64'd4;
      end
      if (keep) begin
        tail    <= tail + PW'(1);
        resp_pc <= resp_pc + 64'd4;
      end
      if (deq) begin
        head <= head + PW'(1);
      end
      if (resp && (drop != '0)) begin
        drop <= drop - CW'(1);
      end
      outstanding <= outstanding_next;
      count_q     <= count_q + CW'(keep) - CW'(deq);
    end
  end

  // Entry storage, cleared on reset so the head outputs read zero afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (keep && !bus.redirect) begin
      instr_mem[tail] <= bus.imem_rdata;
      pc_mem[tail]    <= resp_pc;
    end
  end

  assign bus.imem_req   = issue;
  assign bus.imem_addr  = fetch_pc;
  assign bus.instr_out  = instr_mem[head];
  assign bus.pcaddr_out = pc_mem[head];
  assign bus.out_valid  = (count_q != '0);
  assign bus.count      = count_q;
endmodule
